// File: rtl/adsr_envelope.sv
// ADSR envelope generator: 10-bit level stepped on a prescaled tick, state code for LEDs.
// Optional build macro ADSR_HARD_RETRIGGER_EN clears the level on every gate rise.
module adsr_envelope #(
  parameter int CLKSPEED = 48_000_000,
  parameter int TICK_HZ  = 48_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gate,
  input  logic [7:0] attack_step,
  input  logic [7:0] decay_step,
  input  logic [9:0] sustain_level,
  input  logic [7:0] release_step,
  output logic [9:0] amp_out,
  output logic [2:0] state_out,
  output logic       active
);

  localparam int TICKDIV = CLKSPEED / TICK_HZ;
  localparam int CW      = (TICKDIV > 2) ? $clog2(TICKDIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICKDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [9:0]    r_level, w_level_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_gate_q, r_active;
  logic          w_tick, w_rise, w_fall, w_fall_act;
  logic [10:0]   w_att_sum, w_dec_lim;

  assign w_tick     = (r_cnt == CNT_MAX);
  assign w_rise     = gate & ~r_gate_q;
  assign w_fall     = ~gate & r_gate_q;
  assign w_fall_act = w_fall & ((r_state == S_ATTACK) | (r_state == S_DECAY) |
                                (r_state == S_SUSTAIN));
  assign w_att_sum  = {1'b0, r_level} + {3'b0, attack_step};
  assign w_dec_lim  = {1'b0, sustain_level} + {3'b0, decay_step};

  // State register; prescaler keeps running regardless of gate activity
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_gate_q <= 1'b0;
      r_state  <= S_IDLE;
      r_level  <= '0;
      r_active <= 1'b0;
    end else begin
      r_cnt    <= w_tick ? '0 : r_cnt + 1'b1;
      r_gate_q <= gate;
      r_state  <= w_state_nxt;
      r_level  <= w_level_nxt;
      r_active <= (w_state_nxt != S_IDLE);
    end
  end

  // Next state: gate edges take priority over a coincident tick
  always_comb begin
    w_state_nxt = r_state;
    if (w_rise) begin
      w_state_nxt = S_ATTACK;
    end else if (w_fall_act) begin
      w_state_nxt = S_RELEASE;
    end else if (w_tick) begin
      case (r_state)
        S_ATTACK:  if (w_att_sum >= 11'd1023)                w_state_nxt = S_DECAY;
        S_DECAY:   if ({1'b0, r_level} <= w_dec_lim)         w_state_nxt = S_SUSTAIN;
        S_RELEASE: if (r_level <= {2'b0, release_step})      w_state_nxt = S_IDLE;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // Level datapath; subtractions cannot wrap because the compares gate them
  always_comb begin
    w_level_nxt = r_level;
    if (w_rise) begin
`ifdef ADSR_HARD_RETRIGGER_EN
      w_level_nxt = '0;
`else
      w_level_nxt = r_level;
`endif
    end else if (w_fall_act) begin
      w_level_nxt = r_level;
    end else if (w_tick) begin
      case (r_state)
        S_ATTACK:
          w_level_nxt = (w_att_sum >= 11'd1023) ? 10'd1023 : w_att_sum[9:0];
        S_DECAY:
          w_level_nxt = ({1'b0, r_level} <= w_dec_lim) ? sustain_level
                                                        : r_level - {2'b0, decay_step};
        S_SUSTAIN:
          w_level_nxt = sustain_level;
        S_RELEASE:
          w_level_nxt = (r_level <= {2'b0, release_step}) ? 10'd0
                                                          : r_level - {2'b0, release_step};
        default:
          w_level_nxt = '0;
      endcase
    end
  end

  assign amp_out   = r_level;
  assign state_out = r_state;
  assign active    = r_active;

endmodule

// File: tb/tb_adsr_envelope.sv
// Randomized bench for adsr_envelope against a cycle-level arithmetic reference model.
module tb_adsr_envelope;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gate = 1'b0;
  logic [7:0] attack_step = 8'd200;
  logic [7:0] decay_step = 8'd100;
  logic [9:0] sustain_level = 10'd700;
  logic [7:0] release_step = 8'd255;
  logic [9:0] amp_out;
  logic [2:0] state_out;
  logic       active;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  int m_cnt = 0, m_gq = 0, m_st = 0, m_lvl = 0;

  adsr_envelope #(.CLKSPEED(100), .TICK_HZ(10)) dut (
    .clk(clk), .rst_n(rst_n), .gate(gate),
    .attack_step(attack_step), .decay_step(decay_step),
    .sustain_level(sustain_level), .release_step(release_step),
    .amp_out(amp_out), .state_out(state_out), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, obs, exp_v, $time);
  endtask

  // States: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
  task automatic model_clock();
    int as, ds, sus, rs;
    bit tick, rise, fall;
    as = attack_step; ds = decay_step; sus = sustain_level; rs = release_step;
    if (!rst_n) begin
      m_cnt = 0; m_gq = 0; m_st = 0; m_lvl = 0;
      return;
    end
    tick = (m_cnt == 9);
    rise = gate && (m_gq == 0);
    fall = !gate && (m_gq == 1);
    if (rise) begin
      m_st = 1;
`ifdef ADSR_HARD_RETRIGGER_EN
      m_lvl = 0;
`endif
    end else if (fall && m_st >= 1 && m_st <= 3) begin
      m_st = 4;
    end else if (tick) begin
      case (m_st)
        1: if (m_lvl + as >= 1023) begin m_lvl = 1023; m_st = 2; end
           else m_lvl = m_lvl + as;
        2: if (m_lvl <= sus + ds) begin m_lvl = sus; m_st = 3; end
           else m_lvl = m_lvl - ds;
        3: m_lvl = sus;
        4: if (m_lvl <= rs) begin m_lvl = 0; m_st = 0; end
           else m_lvl = m_lvl - rs;
        default: m_lvl = 0;
      endcase
    end
    m_cnt = tick ? 0 : m_cnt + 1;
    m_gq  = gate ? 1 : 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    chk("amp_out", amp_out, m_lvl);
    chk("state_out", state_out, m_st);
    chk("active", active, (m_st != 0) ? 1 : 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_state(input int target, input int budget);
    for (int i = 0; i < budget && m_st != target; i++) step();
    chk("wait_state", state_out, target);
  endtask

  task automatic wait_level(input int target, input int budget);
    for (int i = 0; i < budget && m_lvl != target; i++) step();
    chk("wait_level", amp_out, target);
  endtask

  initial begin
    // reset held with gate high
    gate = 1'b1;
    rst_n = 1'b0;
    steps(3);
    chk("rst_amp", amp_out, 0);
    chk("rst_state", state_out, 0);
    rst_n = 1'b1;
    steps(2);
    chk("post_rst_attack", state_out, 1);

    // attack -> decay -> sustain
    wait_state(2, 100);
    chk("attack_peak", amp_out, 1023);
    wait_state(3, 100);
    chk("sustain_700", amp_out, 700);
    sustain_level = 10'd650;
    steps(11);
    chk("sustain_follow", amp_out, 650);
    sustain_level = 10'd700;
    steps(11);

    // release to idle
    gate = 1'b0;
    steps(2);
    chk("release_state", state_out, 4);
    wait_state(0, 100);
    chk("release_zero", amp_out, 0);
    chk("release_inactive", active, 0);

    // retrigger from release at 445
    gate = 1'b1;
    wait_state(3, 200);
    gate = 1'b0;
    wait_level(445, 40);
    gate = 1'b1;
    steps(12);
`ifdef ADSR_HARD_RETRIGGER_EN
    chk("retrigger", amp_out, 200);
`else
    chk("retrigger", amp_out, 645);
`endif
    gate = 1'b0;
    wait_state(0, 200);

    // zero attack step holds at 0
    attack_step = 8'd0;
    gate = 1'b1;
    steps(500);
    chk("zero_step_state", state_out, 1);
    chk("zero_step_amp", amp_out, 0);

    // fall coincident with a tick: edge wins, no level update
    for (int i = 0; i < 20 && m_cnt != 9; i++) step();
    gate = 1'b0;
    attack_step = 8'd50;
    step();
    chk("collide_state", state_out, 4);
    chk("collide_amp", amp_out, 0);
    wait_state(0, 40);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) gate = ~gate;
      if ($urandom_range(0, 29) == 0) attack_step = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 29) == 0) decay_step = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 29) == 0) release_step = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 49) == 0) sustain_level = 10'($urandom);
      rst_n = ($urandom_range(0, 799) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
